// File: rtl/sb_frame_rx_pkg.sv
// Shared definitions for the snoop-bus frame receiver: state encoding, delimiters,
// error-bit positions, header grouping and a saturating counter helper.
package sb_frame_rx_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_TYPE,
      RX_SIZE,
      RX_DATA,
      RX_CHK,
      RX_END,
      RX_HOLD
   } Tsb_rx_state;

   localparam logic [7:0] SB_START = 8'hA5;
   localparam logic [7:0] SB_END   = 8'h5A;

   localparam int SB_ERR_CHK  = 0;
   localparam int SB_ERR_END  = 1;
   localparam int SB_ERR_SIZE = 2;

   typedef struct packed {
      logic [7:0] typ;
      logic [7:0] size;
   } Theader;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sb_xor_acc.sv
// 8-bit XOR checksum accumulator; clear has priority over enable.
module sb_xor_acc (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] acc
);

   // Running XOR of every enabled byte since the last clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= 8'd0;
      end else if (clr) begin
         acc <= 8'd0;
      end else if (en) begin
         acc <= acc ^ din;
      end
   end

endmodule

// File: rtl/sb_frame_rx.sv
// Snoop-bus frame receiver: byte stream in, one checked packet out on valid/ready,
// with an inter-byte timeout and a saturating count of bad or dropped frames.
module sb_frame_rx
   import sb_frame_rx_pkg::*;
#(
   parameter int         DATA_BYTES = 4,
   parameter logic [7:0] START_BYTE = SB_START,
   parameter logic [7:0] END_BYTE   = SB_END,
   parameter int         TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              in_byte,
   output logic                    pkt_valid,
   input  logic                    pkt_ready,
   output logic [7:0]              pkt_type,
   output logic [7:0]              pkt_size,
   output logic [8*DATA_BYTES-1:0] pkt_data,
   output logic [3:0]              pkt_err,
   output logic [15:0]             err_count
);

   localparam int         CW           = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [3:0] ERR_END_MASK = 4'(1 << SB_ERR_END);

   Tsb_rx_state             state_r;
   Theader                  hdr_r;
   logic [8*DATA_BYTES-1:0] data_r;
   logic [3:0]              err_r;
   logic [CW-1:0]           cnt_r;
   logic [15:0]             idle_r;
   logic [7:0]              acc_s;
   logic                    take_s;
   logic                    in_frame_s;
   logic                    timeout_s;
   logic                    acc_clr_s;
   logic                    acc_en_s;

   sb_xor_acc u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr_s),
      .en    (acc_en_s),
      .din   (in_byte),
      .acc   (acc_s)
   );

   // Byte acceptance, timeout detection and checksum control.
   always_comb begin
      take_s     = in_valid && in_ready;
      in_frame_s = (state_r != RX_IDLE) && (state_r != RX_HOLD);
      timeout_s  = in_frame_s && (idle_r == 16'(TIMEOUT));
      acc_clr_s  = 1'b0;
      acc_en_s   = 1'b0;
      if (take_s && !timeout_s) begin
         case (state_r)
            RX_IDLE:                   acc_clr_s = (in_byte == START_BYTE);
            RX_TYPE, RX_SIZE, RX_DATA: acc_en_s  = 1'b1;
            default:                   acc_en_s  = 1'b0;
         endcase
      end else begin
         acc_en_s = 1'b0;
      end
   end

   // Frame FSM with registered handshake outputs and error accounting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= RX_IDLE;
         hdr_r     <= '0;
         data_r    <= '0;
         err_r     <= 4'd0;
         cnt_r     <= '0;
         idle_r    <= 16'd0;
         in_ready  <= 1'b1;
         pkt_valid <= 1'b0;
         pkt_type  <= 8'd0;
         pkt_size  <= 8'd0;
         pkt_data  <= '0;
         pkt_err   <= 4'd0;
         err_count <= 16'd0;
      end else if (timeout_s) begin
         // A byte presented in the abort cycle is dropped along with the frame.
         state_r   <= RX_IDLE;
         idle_r    <= 16'd0;
         cnt_r     <= '0;
         err_count <= sat_inc16(err_count);
      end else begin
         if (in_frame_s) begin
            idle_r <= take_s ? 16'd0 : idle_r + 16'd1;
         end else begin
            idle_r <= 16'd0;
         end
         case (state_r)
            RX_IDLE: begin
               if (take_s && (in_byte == START_BYTE)) begin
                  state_r <= RX_TYPE;
                  err_r   <= 4'd0;
                  cnt_r   <= '0;
               end
            end
            RX_TYPE: begin
               if (take_s) begin
                  hdr_r.typ <= in_byte;
                  state_r   <= RX_SIZE;
               end
            end
            RX_SIZE: begin
               if (take_s) begin
                  hdr_r.size          <= in_byte;
                  err_r[SB_ERR_SIZE]  <= ({24'd0, in_byte} > 32'(DATA_BYTES));
                  state_r             <= RX_DATA;
               end
            end
            RX_DATA: begin
               if (take_s) begin
                  data_r[{cnt_r, 3'b000} +: 8] <= in_byte;
                  if (cnt_r == CW'(DATA_BYTES - 1)) begin
                     cnt_r   <= '0;
                     state_r <= RX_CHK;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
            end
            RX_CHK: begin
               if (take_s) begin
                  err_r[SB_ERR_CHK] <= (in_byte != acc_s);
                  state_r           <= RX_END;
               end
            end
            RX_END: begin
               if (take_s) begin
                  pkt_err   <= err_r | ((in_byte != END_BYTE) ? ERR_END_MASK : 4'd0);
                  pkt_type  <= hdr_r.typ;
                  pkt_size  <= hdr_r.size;
                  pkt_data  <= data_r;
                  pkt_valid <= 1'b1;
                  in_ready  <= 1'b0;
                  state_r   <= RX_HOLD;
               end
            end
            RX_HOLD: begin
               if (pkt_ready) begin
                  pkt_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= RX_IDLE;
                  if (pkt_err != 4'd0) begin
                     err_count <= sat_inc16(err_count);
                  end
               end
            end
            default: begin
               state_r   <= RX_IDLE;
               pkt_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sb_frame_rx.sv
// Self-checking bench for sb_frame_rx: directed frames plus randomized frames
// checked against a frame-parsing reference model.
module tb_sb_frame_rx;

   localparam int DB = 4;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [7:0]      in_byte;
   logic            pkt_valid;
   logic            pkt_ready;
   logic [7:0]      pkt_type;
   logic [7:0]      pkt_size;
   logic [8*DB-1:0] pkt_data;
   logic [3:0]      pkt_err;
   logic [15:0]     err_count;

   int         n_chk   = 0;
   int         n_fail  = 0;
   int         exp_cnt = 0;
   logic [7:0] fr[$];

   always #5 clk = ~clk;

   sb_frame_rx #(
      .DATA_BYTES (DB),
      .START_BYTE (8'hA5),
      .END_BYTE   (8'h5A),
      .TIMEOUT    (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_byte   (in_byte),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .pkt_type  (pkt_type),
      .pkt_size  (pkt_size),
      .pkt_data  (pkt_data),
      .pkt_err   (pkt_err),
      .err_count (err_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: parse the byte list as the frame format describes it.
   function automatic void model(output logic [7:0] t, output logic [7:0] s,
                                 output logic [8*DB-1:0] d, output logic [3:0] e);
      int         i = 0;
      logic [7:0] x;
      while (i < fr.size() && fr[i] != 8'hA5) i++;
      i++;
      t = fr[i];
      s = fr[i+1];
      x = t ^ s;
      d = '0;
      for (int k = 0; k < DB; k++) begin
         d[8*k +: 8] = fr[i+2+k];
         x = x ^ fr[i+2+k];
      end
      e = 4'd0;
      if (fr[i+2+DB] != x)     e[0] = 1'b1;
      if (fr[i+3+DB] != 8'h5A) e[1] = 1'b1;
      if (int'(s) > DB)        e[2] = 1'b1;
   endfunction

   task automatic build(input logic [7:0] t, input logic [7:0] s, input logic [8*DB-1:0] d,
                        input logic [7:0] cx, input logic [7:0] eb, input int garb);
      logic [7:0] x;
      logic [7:0] g;
      fr.delete();
      for (int j = 0; j < garb; j++) begin
         g = 8'($urandom_range(255, 0));
         if (g == 8'hA5) g = 8'h00;
         fr.push_back(g);
      end
      fr.push_back(8'hA5);
      fr.push_back(t);
      fr.push_back(s);
      x = t ^ s;
      for (int k = 0; k < DB; k++) begin
         fr.push_back(d[8*k +: 8]);
         x = x ^ d[8*k +: 8];
      end
      fr.push_back(x ^ cx);
      fr.push_back(eb);
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_byte  = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input int hold, input int gap_max, input bit do_hs);
      logic [7:0]      et;
      logic [7:0]      es;
      logic [8*DB-1:0] ed;
      logic [3:0]      ee;
      model(et, es, ed, ee);
      foreach (fr[i]) begin
         repeat ($urandom_range(gap_max, 0)) @(negedge clk);
         send(fr[i]);
      end
      check("pkt_valid_after_end", pkt_valid, 1'b1);
      check("in_ready_in_hold", in_ready, 1'b0);
      check("pkt_type", pkt_type, et);
      check("pkt_size", pkt_size, es);
      check("pkt_data", pkt_data, ed);
      check("pkt_err", pkt_err, ee);
      pkt_ready = 1'b0;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         check("hold_valid", pkt_valid, 1'b1);
         check("hold_in_ready", in_ready, 1'b0);
         check("hold_data", pkt_data, ed);
         check("hold_err", pkt_err, ee);
      end
      if (do_hs) begin
         pkt_ready = 1'b1;
         @(negedge clk);
         pkt_ready = 1'b0;
         if (ee != 4'd0) exp_cnt++;
         check("valid_after_hs", pkt_valid, 1'b0);
         check("in_ready_after_hs", in_ready, 1'b1);
         check("err_count", err_count, 16'(exp_cnt));
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_pkt_valid", pkt_valid, 1'b0);
      check("rst_pkt_type", pkt_type, 8'd0);
      check("rst_pkt_size", pkt_size, 8'd0);
      check("rst_pkt_data", pkt_data, '0);
      check("rst_pkt_err", pkt_err, 4'd0);
      check("rst_err_count", err_count, 16'd0);
   endtask

   initial begin
      in_valid  = 1'b0;
      in_byte   = 8'd0;
      pkt_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);

      // Good frame, checksum 27.
      build(8'h01, 8'h04, 32'hEFBEADDE, 8'h00, 8'h5A, 0);
      check("good_chk_byte", fr[7], 8'h27);
      run_frame(0, 0, 1'b1);
      check("good_err_count", err_count, 16'd0);

      // Checksum 28 and bad End byte.
      build(8'h01, 8'h04, 32'hEFBEADDE, 8'h0F, 8'h5A, 0);
      run_frame(0, 1, 1'b1);
      check("chk_err_count", err_count, 16'd1);
      build(8'h01, 8'h04, 32'hEFBEADDE, 8'h00, 8'h00, 0);
      run_frame(0, 1, 1'b1);

      // Garbage before a good frame.
      build(8'h01, 8'h04, 32'hEFBEADDE, 8'h00, 8'h5A, 0);
      fr.push_front(8'h27);
      fr.push_front(8'h5A);
      fr.push_front(8'hFF);
      fr.push_front(8'h00);
      run_frame(0, 0, 1'b1);

      // Oversized Size field, data still delivered.
      build(8'h01, 8'h06, 32'h44332211, 8'h00, 8'h5A, 0);
      run_frame(0, 0, 1'b1);

      // Backpressure then a back-to-back frame.
      build(8'h3C, 8'h02, 32'hCAFEF00D, 8'h00, 8'h5A, 0);
      run_frame(5, 0, 1'b1);
      build(8'hA5, 8'h04, 32'hA5A5A55A, 8'h00, 8'h5A, 0);
      run_frame(0, 0, 1'b1);

      // Longest tolerated gap inside a frame.
      build(8'h09, 8'h03, 32'h01020304, 8'h00, 8'h5A, 0);
      foreach (fr[i]) begin
         repeat (TO - 1) @(negedge clk);
         send(fr[i]);
      end
      check("gap_max_valid", pkt_valid, 1'b1);
      pkt_ready = 1'b1;
      @(negedge clk);
      pkt_ready = 1'b0;

      // Timeout after three payload bytes; an A5 in the abort cycle is ignored.
      send(8'hA5);
      send(8'h07);
      send(8'h04);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      repeat (TO) @(negedge clk);
      check("to_not_early", err_count, 16'(exp_cnt));
      in_valid = 1'b1;
      in_byte  = 8'hA5;
      @(negedge clk);
      in_valid = 1'b0;
      exp_cnt++;
      check("to_err_count", err_count, 16'(exp_cnt));
      check("to_no_valid", pkt_valid, 1'b0);
      build(8'h55, 8'h01, 32'h0BADBEEF, 8'h00, 8'h5A, 0);
      run_frame(0, 0, 1'b1);

      // Randomized frames.
      for (int n = 0; n < 24; n++) begin
         build(8'($urandom_range(255, 0)), 8'($urandom_range(6, 0)), 32'($urandom()),
               ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00,
               ($urandom_range(4, 0) == 0) ? (8'h5A ^ 8'($urandom_range(255, 1))) : 8'h5A,
               $urandom_range(3, 0));
         run_frame($urandom_range(3, 0), $urandom_range(3, 0), 1'b1);
      end

      // Reset while holding an errored packet.
      build(8'h12, 8'h09, 32'h12345678, 8'h01, 8'h5A, 0);
      run_frame(1, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 0;
      @(negedge clk);

      // Reset mid-DATA after an error has been counted.
      build(8'h01, 8'h04, 32'hEFBEADDE, 8'h0F, 8'h5A, 0);
      run_frame(0, 0, 1'b1);
      send(8'hA5);
      send(8'h01);
      send(8'h04);
      send(8'hDE);
      send(8'hAD);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 0;
      @(negedge clk);
      build(8'h01, 8'h04, 32'hEFBEADDE, 8'h00, 8'h5A, 0);
      run_frame(0, 0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
